// File: rtl/led_pattern_scheduler_if.sv
// Bundle between the requesting logic and the LED pattern scheduler.
// The master side drives requests and patterns; the slave side returns grants, status and LED drive.
interface led_pattern_scheduler_if #(
    parameter int NREQ    = 3,
    parameter int PAT_LEN = 8
);
    logic [NREQ-1:0]           REQ;
    logic [NREQ*2*PAT_LEN-1:0] PAT;
    logic [NREQ-1:0]           GNT;
    logic                      DONE;
    logic                      BUSY;
    logic                      STEP_STROBE;
    logic                      LED1;
    logic                      LED2;

    modport master (
        output REQ, PAT,
        input  GNT, DONE, BUSY, STEP_STROBE, LED1, LED2
    );

    modport slave (
        input  REQ, PAT,
        output GNT, DONE, BUSY, STEP_STROBE, LED1, LED2
    );
endinterface

// File: rtl/led_pattern_scheduler.sv
// Plays fixed-length two-LED patterns at a slow step rate, sharing the LEDs between
// requesters through non-preemptive round-robin arbitration.
module led_pattern_scheduler #(
    parameter int CLK_HZ  = 100000000,
    parameter int STEP_HZ = 8,
    parameter int PAT_LEN = 8,
    parameter int NREQ    = 3
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    led_pattern_scheduler_if.slave        bus
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(PAT_LEN);
    localparam int RW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW  = 2 * PAT_LEN;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [RW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   pat_q, pat_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            done_q, done_d;

    logic [SW-1:0]   pat_slice [NREQ];
    logic [RW-1:0]   winner;
    logic            found;
    int              cand;
    logic            step_last;
    logic            idx_last;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign pat_slice[gi] = bus.PAT[gi*SW +: SW];
    end

    // First set request at or above the pointer, wrapping at NREQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && bus.REQ[cand]) begin
                found  = 1'b1;
                winner = RW'(cand);
            end
        end
    end

    assign step_last = (presc_q == PW'(DIV - 1));
    assign idx_last  = (idx_q == IW'(PAT_LEN - 1));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        pat_d   = pat_q;
        gnt_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = PLAY;
                    presc_d       = '0;
                    idx_d         = '0;
                    ptr_d         = (winner == RW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    pat_d         = pat_slice[winner];
                    gnt_d[winner] = 1'b1;
                end
            end
            PLAY: begin
                if (step_last) begin
                    presc_d = '0;
                    if (idx_last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            presc_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            pat_q   <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            pat_q   <= pat_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    // LEDs decode straight from the latched pattern so step 0 shows alongside GNT.
    assign bus.GNT         = gnt_q;
    assign bus.DONE        = done_q;
    assign bus.BUSY        = (state_q == PLAY);
    assign bus.STEP_STROBE = (state_q == PLAY) && step_last;
    assign bus.LED1        = (state_q == PLAY) && pat_q[{idx_q, 1'b0}];
    assign bus.LED2        = (state_q == PLAY) && pat_q[{idx_q, 1'b1}];
endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a monitor pops and compares them.
module tb_led_pattern_scheduler;
    localparam int NREQ    = 3;
    localparam int PAT_LEN = 4;

    typedef struct {
        int         cyc;
        logic [2:0] gnt;
        logic       done;
        logic       busy;
        logic       strobe;
        logic [1:0] leds;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic stim_done = 1'b0;
    exp_t exp_q[$];

    led_pattern_scheduler_if #(.NREQ(NREQ), .PAT_LEN(PAT_LEN)) bus ();

    led_pattern_scheduler #(
        .CLK_HZ (8),
        .STEP_HZ(2),
        .PAT_LEN(PAT_LEN),
        .NREQ   (NREQ)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_zero(input int c);
        exp_t e;
        e.cyc = c; e.gnt = 3'b000; e.done = 1'b0; e.busy = 1'b0; e.strobe = 1'b0; e.leds = 2'b00;
        exp_q.push_back(e);
    endtask

    // Steps given as {LED2,LED1}; ncyc=17 covers the full pattern plus its DONE cycle.
    task automatic push_pattern(input int t, input int r, input logic [1:0] s0, input logic [1:0] s1,
                                input logic [1:0] s2, input logic [1:0] s3, input int ncyc);
        exp_t e;
        logic [1:0] steps [4];
        steps[0] = s0; steps[1] = s1; steps[2] = s2; steps[3] = s3;
        for (int k = 0; k < ncyc; k++) begin
            e.cyc = t + k;
            if (k < 16) begin
                e.gnt    = (k == 0) ? 3'(1 << r) : 3'b000;
                e.done   = 1'b0;
                e.busy   = 1'b1;
                e.strobe = ((k % 4) == 3);
                e.leds   = steps[k / 4];
            end else begin
                e.gnt = 3'b000; e.done = 1'b1; e.busy = 1'b0; e.strobe = 1'b0; e.leds = 2'b00;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [1:0] leds_act;
        leds_act = {bus.LED2, bus.LED1};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_cycle %0d: expectation never compared (now cycle %0d)", e.cyc, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.GNT !== e.gnt || bus.DONE !== e.done || bus.BUSY !== e.busy ||
                bus.STEP_STROBE !== e.strobe || leds_act !== e.leds) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got gnt=%b done=%b busy=%b strobe=%b leds=%b, expected gnt=%b done=%b busy=%b strobe=%b leds=%b",
                         cyc, bus.GNT, bus.DONE, bus.BUSY, bus.STEP_STROBE, leds_act,
                         e.gnt, e.done, e.busy, e.strobe, e.leds);
            end else begin
                $display("cycle %0d ok: gnt=%b done=%b busy=%b strobe=%b leds=%b",
                         cyc, bus.GNT, bus.DONE, bus.BUSY, bus.STEP_STROBE, leds_act);
            end
        end else if (bus.GNT !== 3'b000 || bus.DONE !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event cycle %0d: got gnt=%b done=%b, expected gnt=000 done=0",
                     cyc, bus.GNT, bus.DONE);
        end
        if (stim_done && exp_q.size() == 0) begin
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
        if (cyc > 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d pending expectations, expected 0", exp_q.size());
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        // Reset held for three edges with all requests up; outputs stay quiet through release.
        rst_n   = 1'b0;
        bus.REQ = 3'b111;
        bus.PAT = {8'h1B, 8'hC9, 8'hE4};
        for (int c = 1; c <= 4; c++) push_zero(c);
        goto_cycle(3);
        rst_n   = 1'b1;
        bus.REQ = 3'b000;

        // Round-robin with all requesters held: 0, 1, 2, 0 every 17 cycles.
        goto_cycle(4);
        bus.REQ = 3'b111;
        push_pattern(5,  0, 2'b00, 2'b01, 2'b10, 2'b11, 17);
        push_pattern(22, 1, 2'b01, 2'b10, 2'b00, 2'b11, 17);
        push_pattern(39, 2, 2'b11, 2'b10, 2'b01, 2'b00, 17);
        push_pattern(56, 0, 2'b00, 2'b01, 2'b10, 2'b11, 17);
        goto_cycle(56);
        bus.REQ = 3'b000;

        // PAT change during PLAY must not disturb the latched pattern.
        goto_cycle(72);
        bus.REQ = 3'b001;
        push_pattern(73, 0, 2'b00, 2'b01, 2'b10, 2'b11, 17);
        goto_cycle(73);
        bus.REQ = 3'b000;
        goto_cycle(78);
        bus.PAT[7:0] = 8'h1B;

        // Single request on requester 2, then reset mid-play; pointer must restart at 0.
        goto_cycle(90);
        bus.REQ = 3'b100;
        push_pattern(91, 2, 2'b11, 2'b10, 2'b01, 2'b00, 6);
        push_zero(97);
        push_zero(98);
        goto_cycle(91);
        bus.REQ = 3'b000;
        goto_cycle(96);
        rst_n   = 1'b0;
        bus.REQ = 3'b111;
        goto_cycle(98);
        rst_n = 1'b1;
        push_pattern(99, 0, 2'b11, 2'b10, 2'b01, 2'b00, 17);
        goto_cycle(99);
        bus.REQ = 3'b000;

        // One-cycle request pulse: exactly one pattern, then quiet.
        goto_cycle(116);
        bus.REQ = 3'b001;
        push_pattern(117, 0, 2'b11, 2'b10, 2'b01, 2'b00, 17);
        for (int c = 134; c <= 143; c++) push_zero(c);
        goto_cycle(117);
        bus.REQ = 3'b000;

        goto_cycle(145);
        stim_done = 1'b1;
    end
endmodule
